pipe_alu_fwd: RTL

PIPE_ALU_FWD -- requirements
Module: pipe_alu_fwd

---
 rtl/pipe_alu_fwd.sv | 128 ++++++++++++
 1 files changed

// File: rtl/pipe_alu_fwd.sv
// Four-stage ALU pipeline: S1 latch, S2 operand read/execute, S3 writeback, S4 store.
// S2 forwards the S3 result, so dependent instructions issue back to back without stalling.
module pipe_alu_fwd #(
  parameter  int DW   = 16,
  parameter  int NREG = 16,
  parameter  int AW   = 8,
  localparam int RW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hold,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [RW-1:0] rs1,
  input  logic [RW-1:0] rs2,
  input  logic [RW-1:0] rd,
  input  logic [3:0]    func,
  input  logic [AW-1:0] addr,
  output logic [DW-1:0] y,
  output logic          y_valid,
  output logic          y_zero,
  input  logic [AW-1:0] mem_raddr,
  output logic [DW-1:0] mem_rdata
);

  logic          s1_valid_q;
  logic [RW-1:0] s1_rs1_q, s1_rs2_q, s1_rd_q;
  logic [3:0]    s1_func_q;
  logic [AW-1:0] s1_addr_q;

  logic          s3_valid_q;
  logic [RW-1:0] s3_rd_q;
  logic [AW-1:0] s3_addr_q;
  logic [DW-1:0] s3_res_q;

  logic          s4_valid_q;
  logic [AW-1:0] s4_addr_q;

  logic [DW-1:0] y_q;
  logic          y_zero_q;
  logic          y_valid_q;
  logic [DW-1:0] mem_rdata_q;

  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] mem_q  [2**AW];

  logic [DW-1:0] op_a, op_b, res_d;

  // The instruction in S3 has not yet reached the regbank, so its result wins.
  always_comb begin
    op_a = regs_q[s1_rs1_q];
    op_b = regs_q[s1_rs2_q];
    if (s3_valid_q && (s3_rd_q == s1_rs1_q)) op_a = s3_res_q;
    if (s3_valid_q && (s3_rd_q == s1_rs2_q)) op_b = s3_res_q;
  end

  always_comb begin
    res_d = '1;
    case (s1_func_q)
      4'd0:  res_d = op_a + op_b;
      4'd1:  res_d = op_a - op_b;
      4'd2:  res_d = op_a * op_b;
      4'd3:  res_d = op_a >> 1;
      4'd4:  res_d = op_b >> 1;
      4'd5:  res_d = op_a << 1;
      4'd6:  res_d = op_b << 1;
      4'd7:  res_d = ~op_a;
      4'd8:  res_d = ~op_b;
      4'd9:  res_d = op_a & op_b;
      4'd10: res_d = op_a | op_b;
      4'd11: res_d = op_a ^ op_b;
      4'd12: res_d = op_a;
      default: res_d = '1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
      s4_valid_q <= 1'b0;
      y_q        <= '0;
      y_zero_q   <= 1'b1;
      y_valid_q  <= 1'b0;
    end else if (hold) begin
      y_valid_q  <= 1'b0;
    end else begin
      s1_valid_q <= in_valid;
      s1_rs1_q   <= rs1;
      s1_rs2_q   <= rs2;
      s1_rd_q    <= rd;
      s1_func_q  <= func;
      s1_addr_q  <= addr;
      s3_valid_q <= s1_valid_q;
      s3_rd_q    <= s1_rd_q;
      s3_addr_q  <= s1_addr_q;
      s3_res_q   <= res_d;
      s4_valid_q <= s3_valid_q;
      s4_addr_q  <= s3_addr_q;
      y_valid_q  <= s3_valid_q;
      if (s3_valid_q) begin
        y_q      <= s3_res_q;
        y_zero_q <= (s3_res_q == '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (!hold && s3_valid_q) begin
      regs_q[s3_rd_q] <= s3_res_q;
    end
  end

  // Memory is never cleared; the debug read port runs even while the pipeline is held.
  always_ff @(posedge clk) begin
    if (!rst && !hold && s4_valid_q) mem_q[s4_addr_q] <= y_q;
    mem_rdata_q <= mem_q[mem_raddr];
  end

  assign in_ready  = ~hold;
  assign y         = y_q;
  assign y_valid   = y_valid_q;
  assign y_zero    = y_zero_q;
  assign mem_rdata = mem_rdata_q;

endmodule
